// File: rtl/dtcore32_pkg.sv
// Shared types for the dtcore32 pipeline: load sizes, writeback FSM states,
// the captured load context and register-file constants.
package dtcore32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RADR_W = 5;

  localparam logic [RADR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_RESP = 1'b1
  } wb_state_e;

  // Everything a load needs at completion, latched when MEM hands it over
  typedef struct packed {
    logic                rd_write;
    logic [RADR_W-1:0]   rd_addr;
    load_size_e          size;
    logic                is_unsigned;
    logic [1:0]          addr_lo;
  } load_ctx_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Byte/half/word lane select and sign/zero extension of a word-aligned read.
// Purely combinational; shared with the store-forwarding path.
module load_align
  import dtcore32_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  load_size_e      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] ext_data_c_o
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      lane8;
  logic [15:0]     lane16;

  always_comb begin
    shifted      = rdata_i >> {addr_lo_i, 3'b000};
    lane8        = shifted[7:0];
    lane16       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ext_data_c_o = rdata_i;
    case (size_i)
      LS_BYTE: ext_data_c_o = {{24{~unsigned_i & lane8[7]}}, lane8};
      LS_HALF: ext_data_c_o = {{16{~unsigned_i & lane16[15]}}, lane16};
      default: ext_data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle into the register file,
// stalling MEM while a load response is outstanding. Optional macro:
// WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output.
module wb_stage
  import dtcore32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_is_rd_write,
  input  logic [4:0]      mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            mem_is_load,
  input  logic [1:0]      mem_load_size,
  input  logic            mem_load_unsigned,
  input  logic [1:0]      mem_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_q_is_rd_write,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_wdata,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]     wb_retire_cnt,
`endif
  output logic            wb_busy
);

  wb_state_e       state_q, state_d;
  load_ctx_t       ctx_q, ctx_d, live_ctx, al_ctx;
  logic            we_q, we_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] aligned;
  logic            xfer, alu_retire, ld_done;

  // State register plus datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      ctx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state: park in WAIT_RESP only if the response did not arrive with the load
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE:      if (mem_valid && mem_is_load && !dmem_rvalid) state_d = WB_WAIT_RESP;
      WB_WAIT_RESP: if (dmem_rvalid) state_d = WB_IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    mem_ready = 1'b0;
    wb_busy   = 1'b0;
    unique case (state_q)
      WB_IDLE:      mem_ready = 1'b1;
      WB_WAIT_RESP: wb_busy   = 1'b1;
    endcase
  end

  always_comb begin
    live_ctx.rd_write    = mem_is_rd_write;
    live_ctx.rd_addr     = mem_rd_addr;
    live_ctx.size        = load_size_e'(mem_load_size);
    live_ctx.is_unsigned = mem_load_unsigned;
    live_ctx.addr_lo     = mem_addr_lo;
  end

  // A same-cycle response aligns using the live MEM fields, otherwise the captured ones
  assign al_ctx = (state_q == WB_IDLE) ? live_ctx : ctx_q;

  load_align u_align (
    .rdata_i      (dmem_rdata),
    .size_i       (al_ctx.size),
    .unsigned_i   (al_ctx.is_unsigned),
    .addr_lo_i    (al_ctx.addr_lo),
    .ext_data_c_o (aligned)
  );

  assign xfer       = mem_valid && mem_ready;
  assign alu_retire = xfer && !mem_is_load;
  assign ld_done    = dmem_rvalid && ((xfer && mem_is_load) || (state_q == WB_WAIT_RESP));

  // Register-file write: one-cycle enable pulse, address/data hold otherwise
  always_comb begin
    ctx_d  = ctx_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (xfer && mem_is_load) ctx_d = live_ctx;
    if (alu_retire) begin
      we_d   = mem_is_rd_write && (mem_rd_addr != REG_ZERO);
      addr_d = mem_rd_addr;
      data_d = mem_result;
    end else if (ld_done) begin
      we_d   = al_ctx.rd_write && (al_ctx.rd_addr != REG_ZERO);
      addr_d = al_ctx.rd_addr;
      data_d = aligned;
    end
  end

  assign wb_q_is_rd_write = we_q;
  assign wb_rd_addr       = addr_q;
  assign wb_rd_wdata      = data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q, cnt_d;

  // Loads count at completion, ALU ops at acceptance; wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (alu_retire || ld_done) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign wb_retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: register-file writes are scoreboarded,
// handshake/busy/hold behaviour and reset are checked directly.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid, mem_ready, mem_is_rd_write, mem_is_load, mem_load_unsigned;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic [1:0]  mem_load_size, mem_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_q_is_rd_write, wb_busy;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] wb_retire_cnt;
`endif

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     sb_q[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [63:0] exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  wb_stage #(.XLEN(32)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_is_rd_write   (mem_is_rd_write),
    .mem_rd_addr       (mem_rd_addr),
    .mem_result        (mem_result),
    .mem_is_load       (mem_is_load),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_addr_lo       (mem_addr_lo),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .wb_q_is_rd_write  (wb_q_is_rd_write),
    .wb_rd_addr        (wb_rd_addr),
    .wb_rd_wdata       (wb_rd_wdata),
`ifdef WB_RETIRE_CNT_EN
    .wb_retire_cnt     (wb_retire_cnt),
`endif
    .wb_busy           (wb_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [1:0] lo);
    logic [31:0] v;
    case (size)
      2'd0: begin
        v = (rdata >> (32'(lo) * 8)) & 32'h0000_00FF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = lo[1] ? (rdata >> 16) : (rdata & 32'h0000_FFFF);
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk_i) begin
    if (wb_q_is_rd_write) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(wb_rd_addr), 64'h0);
      end else begin
        wr_exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", 64'(wb_rd_addr), 64'(e.addr));
        check("wr_data", 64'(wb_rd_wdata), 64'(e.data));
      end
    end
  end

  task automatic idle_inputs();
    mem_valid = 0; mem_is_rd_write = 0; mem_rd_addr = 0; mem_result = 0;
    mem_is_load = 0; mem_load_size = 0; mem_load_unsigned = 0; mem_addr_lo = 0;
    dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic check_cnt(input string tag);
`ifdef WB_RETIRE_CNT_EN
    check(tag, wb_retire_cnt, exp_cnt);
`endif
  endtask

  // Non-load transfer at the current negedge; returns at the negedge after it retires
  task automatic do_alu(input logic [4:0] rd, input logic wr, input logic [31:0] res);
    mem_valid = 1; mem_is_load = 0; mem_is_rd_write = wr; mem_rd_addr = rd; mem_result = res;
    if (wr && rd != 0) sb_q.push_back('{addr: rd, data: res});
    @(negedge clk_i);
    mem_valid = 0;
    exp_cnt++;
    check_cnt("cnt_alu");
  endtask

  // Load transfer with response dly cycles later (0 = same cycle)
  task automatic do_load(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                         input logic [1:0] lo, input logic [31:0] rdata, input int dly);
    mem_valid = 1; mem_is_load = 1; mem_is_rd_write = 1; mem_rd_addr = rd;
    mem_load_size = size; mem_load_unsigned = uns; mem_addr_lo = lo;
    mem_result = 32'hA5A5_A5A5;
    dmem_rvalid = (dly == 0); dmem_rdata = (dly == 0) ? rdata : 32'h0;
    if (rd != 0) sb_q.push_back('{addr: rd, data: ld_model(rdata, size, uns, lo)});
    @(negedge clk_i);
    mem_valid = 0; dmem_rvalid = 0;
    mem_load_size = 2'd2; mem_addr_lo = 2'd0; mem_load_unsigned = 0;
    for (int i = 0; i < dly; i++) begin
      check("wait_busy", 64'(wb_busy), 64'h1);
      check("wait_ready", 64'(mem_ready), 64'h0);
      check("wait_no_we", 64'(wb_q_is_rd_write), 64'h0);
      check_cnt("cnt_wait");
      if (i == dly - 1) begin
        dmem_rvalid = 1; dmem_rdata = rdata;
      end
      @(negedge clk_i);
    end
    dmem_rvalid = 0;
    exp_cnt++;
    check("ld_we", 64'(wb_q_is_rd_write), 64'(rd != 0));
    check("ld_busy", 64'(wb_busy), 64'h0);
    check("ld_ready", 64'(mem_ready), 64'h1);
    check_cnt("cnt_load");
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    check("rst_we", 64'(wb_q_is_rd_write), 64'h0);
    check("rst_addr", 64'(wb_rd_addr), 64'h0);
    check("rst_data", 64'(wb_rd_wdata), 64'h0);
    check("rst_busy", 64'(wb_busy), 64'h0);
    check("rst_ready", 64'(mem_ready), 64'h1);
    check_cnt("rst_cnt");
    rst_i = 0;

    do_alu(5'd5, 1'b1, 32'h1234_5678);
    check("alu_we", 64'(wb_q_is_rd_write), 64'h1);
    @(negedge clk_i);
    check("alu_pulse_low", 64'(wb_q_is_rd_write), 64'h0);
    check("alu_hold_addr", 64'(wb_rd_addr), 64'h5);
    check("alu_hold_data", 64'(wb_rd_wdata), 64'h1234_5678);

    do_load(5'd7, 2'd0, 1'b0, 2'd3, 32'h80FF_0000, 3);
    check("lb_data", 64'(wb_rd_wdata), 64'hFFFF_FF80);

    do_load(5'd9, 2'd1, 1'b1, 2'd2, 32'hBEEF_0001, 0);
    check("lhu_data", 64'(wb_rd_wdata), 64'h0000_BEEF);
    check("lhu_ready", 64'(mem_ready), 64'h1);
    @(negedge clk_i);

    do_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
    check("rd0_no_we", 64'(wb_q_is_rd_write), 64'h0);
    check("rd0_data", 64'(wb_rd_wdata), 64'hDEAD_BEEF);
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk_i);
    dmem_rvalid = 0;
    check("spur_no_we", 64'(wb_q_is_rd_write), 64'h0);
    check("spur_busy", 64'(wb_busy), 64'h0);
    check("spur_ready", 64'(mem_ready), 64'h1);
    check("spur_hold", 64'(wb_rd_wdata), 64'hDEAD_BEEF);
    check_cnt("spur_cnt");

    // Random loads of every size/lane/extension, back-to-back with ALU ops
    for (int n = 0; n < 24; n++) begin
      do_load(5'($urandom_range(31, 1)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
              2'($urandom_range(3, 0)), $urandom, $urandom_range(2, 0));
      do_alu(5'($urandom_range(31, 1)), 1'b1, $urandom);
    end
    do_load(5'd12, 2'd3, 1'b0, 2'd3, 32'h8000_0001, 1);
    check("rsvd_word", 64'(wb_rd_wdata), 64'h8000_0001);

    // Reset while a word load is pending, then a stray response
    mem_valid = 1; mem_is_load = 1; mem_is_rd_write = 1; mem_rd_addr = 5'd3;
    mem_load_size = 2'd2; mem_addr_lo = 2'd0;
    @(negedge clk_i);
    mem_valid = 0;
    check("lw_busy", 64'(wb_busy), 64'h1);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    exp_cnt = 0;
    check("rr_we", 64'(wb_q_is_rd_write), 64'h0);
    check("rr_addr", 64'(wb_rd_addr), 64'h0);
    check("rr_data", 64'(wb_rd_wdata), 64'h0);
    check("rr_busy", 64'(wb_busy), 64'h0);
    check("rr_ready", 64'(mem_ready), 64'h1);
    check_cnt("rr_cnt");
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk_i);
    dmem_rvalid = 0;
    check("stray_no_we", 64'(wb_q_is_rd_write), 64'h0);
    check("stray_data", 64'(wb_rd_wdata), 64'h0);
    check("stray_ready", 64'(mem_ready), 64'h1);
    check_cnt("stray_cnt");

    // Three ALU ops and one load from a fresh count
    do_alu(5'd1, 1'b1, 32'h1);
    do_alu(5'd2, 1'b1, 32'h2);
    do_alu(5'd3, 1'b0, 32'h3);
    do_load(5'd4, 2'd2, 1'b0, 2'd0, 32'h0404_0404, 2);
`ifdef WB_RETIRE_CNT_EN
    check("cnt_four", wb_retire_cnt, 64'd4);
`endif

    repeat (2) @(negedge clk_i);
    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
